// File: rtl/jtag_bus_cmd_ctrl_if.sv
// Handshake/bus bundle for the JTAG bus command controller.
//   cmd_*    : command word in from the JTAG decode, cmd_ready back
//   rsp_*    : completion pulse, read data and timeout flag to DR capture
//   ipcore_* : single-word job request to the DMA engine and its idle flag
//   buffer   : second port of the shared word buffer (location 0 only)
//   cur_addr : address register, for debug/status capture
// slave modport = controller side, master modport = environment side.
interface jtag_bus_cmd_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_opcode;
  logic        cmd_autoinc;
  logic [3:0]  cmd_byteEnable;
  logic [31:0] cmd_word;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        ipcore_dataReady;
  logic        ipcore_readReady;
  logic [3:0]  ipcore_byteEnable;
  logic [31:0] ipcore_address_to_read;
  logic        ipcore_switch_ready;
  logic [8:0]  bufferAddress;
  logic [31:0] dataIn;
  logic        writeEnable;
  logic [31:0] dataOut;
  logic [31:0] cur_addr;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_autoinc, cmd_byteEnable, cmd_word,
    input  ipcore_switch_ready, dataOut,
    output cmd_ready, rsp_valid, rsp_data, rsp_timeout,
    output ipcore_dataReady, ipcore_readReady, ipcore_byteEnable, ipcore_address_to_read,
    output bufferAddress, dataIn, writeEnable, cur_addr
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_autoinc, cmd_byteEnable, cmd_word,
    output ipcore_switch_ready, dataOut,
    input  cmd_ready, rsp_valid, rsp_data, rsp_timeout,
    input  ipcore_dataReady, ipcore_readReady, ipcore_byteEnable, ipcore_address_to_read,
    input  bufferAddress, dataIn, writeEnable, cur_addr
  );
endinterface

// File: rtl/jtag_bus_cmd_ctrl.sv
// JTAG bus command controller: accepts NOP/SETADDR/WRITE/READ command words,
// stages write data in buffer location 0, issues one single-word DMA job at a
// time, tracks it via ipcore_switch_ready and returns data/status.
// Ports: clock, reset (async active-low), bus (jtag_bus_cmd_ctrl_if.slave).
module jtag_bus_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_INC       = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  jtag_bus_cmd_ctrl_if.slave        bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_SETADDR = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [1:0] OP_READ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_BUF_WR, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_BUF_RD, S_RESP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  tcnt;
  logic [31:0]       addr_reg;
  logic              autoinc;
  logic [3:0]        be_q;
  logic              op_write;
  logic              op_mem;
  logic              rd_wait;

  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_timeout_q;
  logic              data_ready_q;
  logic              read_ready_q;
  logic [3:0]        ip_be_q;
  logic [31:0]       ip_addr_q;
  logic              we_q;
  logic [31:0]       data_in_q;

  logic              tmo_c;
  assign tmo_c = (tcnt == CNT_LAST);

  assign bus.cmd_ready              = cmd_ready_q;
  assign bus.rsp_valid              = rsp_valid_q;
  assign bus.rsp_data               = rsp_data_q;
  assign bus.rsp_timeout            = rsp_timeout_q;
  assign bus.ipcore_dataReady       = data_ready_q;
  assign bus.ipcore_readReady       = read_ready_q;
  assign bus.ipcore_byteEnable      = ip_be_q;
  assign bus.ipcore_address_to_read = ip_addr_q;
  assign bus.bufferAddress          = 9'd0;
  assign bus.dataIn                 = data_in_q;
  assign bus.writeEnable            = we_q;
  assign bus.cur_addr               = addr_reg;

  // Command FSM with registered outputs; outputs change together with state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      tcnt          <= '0;
      addr_reg      <= '0;
      autoinc       <= 1'b0;
      be_q          <= '0;
      op_write      <= 1'b0;
      op_mem        <= 1'b0;
      rd_wait       <= 1'b0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      data_ready_q  <= 1'b0;
      read_ready_q  <= 1'b0;
      ip_be_q       <= '0;
      ip_addr_q     <= '0;
      we_q          <= 1'b0;
      data_in_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            case (bus.cmd_opcode)
              OP_NOP: begin
                op_mem      <= 1'b0;
                rsp_valid_q <= 1'b1;
                state       <= S_RESP;
              end
              OP_SETADDR: begin
                addr_reg    <= bus.cmd_word;
                autoinc     <= bus.cmd_autoinc;
                op_mem      <= 1'b0;
                rsp_valid_q <= 1'b1;
                state       <= S_RESP;
              end
              OP_WRITE: begin
                be_q      <= bus.cmd_byteEnable;
                op_write  <= 1'b1;
                op_mem    <= 1'b1;
                we_q      <= 1'b1;
                data_in_q <= bus.cmd_word;
                state     <= S_BUF_WR;
              end
              default: begin // OP_READ
                be_q     <= bus.cmd_byteEnable;
                op_write <= 1'b0;
                op_mem   <= 1'b1;
                tcnt     <= '0;
                state    <= S_ISSUE;
              end
            endcase
          end
        end
        S_BUF_WR: begin
          we_q      <= 1'b0;
          data_in_q <= '0;
          tcnt      <= '0;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (bus.ipcore_switch_ready) begin
            data_ready_q <= op_write;
            read_ready_q <= ~op_write;
            ip_addr_q    <= addr_reg;
            ip_be_q      <= be_q;
            tcnt         <= '0;
            state        <= S_WAIT_START;
          end else if (tmo_c) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state         <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WAIT_START: begin
          // Request is a single-cycle pulse regardless of how long we wait here.
          data_ready_q <= 1'b0;
          read_ready_q <= 1'b0;
          if (!bus.ipcore_switch_ready) begin
            tcnt  <= '0;
            state <= S_WAIT_DONE;
          end else if (tmo_c) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state         <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (bus.ipcore_switch_ready) begin
            if (op_write) begin
              rsp_valid_q <= 1'b1;
              state       <= S_RESP;
            end else begin
              rd_wait <= 1'b0;
              state   <= S_BUF_RD;
            end
          end else if (tmo_c) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state         <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_BUF_RD: begin
          // First cycle presents address 0; dataOut is valid in the second.
          if (rd_wait) begin
            rsp_data_q  <= bus.dataOut;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end
          rd_wait <= ~rd_wait;
        end
        S_RESP: begin
          rsp_valid_q   <= 1'b0;
          rsp_data_q    <= '0;
          rsp_timeout_q <= 1'b0;
          cmd_ready_q   <= 1'b1;
          if (autoinc && op_mem && !rsp_timeout_q) begin
            addr_reg <= addr_reg + 32'(ADDR_INC);
          end
          state <= S_IDLE;
        end
        default: begin
          cmd_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_bus_cmd_ctrl.sv
// Directed bench for jtag_bus_cmd_ctrl with a behavioural DMA/buffer model
// and scoreboards for DMA requests and command responses.
module tb_jtag_bus_cmd_ctrl;

  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [31:0] data;
    logic        tmo;
  } rsp_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
  } req_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  jtag_bus_cmd_ctrl_if bus ();

  jtag_bus_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_INC(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks    = 0;
  int failures  = 0;
  int rsp_count = 0;
  int req_count = 0;
  int we_count  = 0;

  rsp_t exp_rsp[$];
  req_t exp_req[$];

  // DMA + buffer model
  logic [31:0] buf_word    = '0;
  logic [31:0] dma_rdata   = '0;
  logic [31:0] dma_wcap    = '0;
  logic        dma_is_read = 1'b0;
  logic        dma_hold_low = 1'b0;
  int          dma_busy    = 4;
  int          dma_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) begin
    if (dma_cnt != 0) begin
      dma_cnt <= dma_cnt - 1;
      if (dma_cnt == 1) begin
        bus.ipcore_switch_ready <= 1'b1;
        if (dma_is_read) buf_word <= dma_rdata;
        else             dma_wcap <= buf_word;
      end
    end else if (dma_hold_low) begin
      bus.ipcore_switch_ready <= 1'b0;
    end else if (bus.ipcore_dataReady || bus.ipcore_readReady) begin
      bus.ipcore_switch_ready <= 1'b0;
      dma_cnt     <= dma_busy;
      dma_is_read <= bus.ipcore_readReady;
    end else begin
      bus.ipcore_switch_ready <= 1'b1;
    end
    if (bus.writeEnable && bus.bufferAddress == 9'd0) buf_word <= bus.dataIn;
    bus.dataOut <= buf_word;
  end

  // Output monitor: pops scoreboards as responses and requests appear.
  always @(negedge clock) begin
    if (reset) begin
      if (bus.rsp_valid) begin
        rsp_t e;
        rsp_count++;
        check("rsp_expected", 32'(exp_rsp.size() > 0), 32'd1);
        if (exp_rsp.size() > 0) begin
          e = exp_rsp.pop_front();
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
        end
      end
      if (bus.ipcore_dataReady || bus.ipcore_readReady) begin
        req_t r;
        req_count++;
        check("req_exclusive", 32'(bus.ipcore_dataReady & bus.ipcore_readReady), 32'd0);
        check("req_expected", 32'(exp_req.size() > 0), 32'd1);
        if (exp_req.size() > 0) begin
          r = exp_req.pop_front();
          check("req_is_write", 32'(bus.ipcore_dataReady), 32'(r.wr));
          check("req_addr", bus.ipcore_address_to_read, r.addr);
          check("req_be", 32'(bus.ipcore_byteEnable), 32'(r.be));
        end
      end
      if (bus.writeEnable) begin
        we_count++;
        check("buf_addr", 32'(bus.bufferAddress), 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({pfx, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({pfx, "_rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
    check({pfx, "_dataReady"}, 32'(bus.ipcore_dataReady), 32'd0);
    check({pfx, "_readReady"}, 32'(bus.ipcore_readReady), 32'd0);
    check({pfx, "_ip_be"}, 32'(bus.ipcore_byteEnable), 32'd0);
    check({pfx, "_ip_addr"}, bus.ipcore_address_to_read, 32'd0);
    check({pfx, "_we"}, 32'(bus.writeEnable), 32'd0);
    check({pfx, "_dataIn"}, bus.dataIn, 32'd0);
    check({pfx, "_bufaddr"}, 32'(bus.bufferAddress), 32'd0);
    check({pfx, "_cur_addr"}, bus.cur_addr, 32'd0);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic ai, input logic [3:0] be,
                          input logic [31:0] w);
    int n = 0;
    @(negedge clock);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_opcode     = op;
    bus.cmd_autoinc    = ai;
    bus.cmd_byteEnable = be;
    bus.cmd_word       = w;
    bus.cmd_valid      = 1'b1;
    @(negedge clock);
    bus.cmd_valid      = 1'b0;
  endtask

  task automatic wait_count(input string tag, input int which, input int target, input int budget);
    int n = 0;
    while (((which == 0) ? rsp_count : req_count) < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(((which == 0) ? rsp_count : req_count) >= target), 32'd1);
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic t);
    rsp_t e;
    e.data = d;
    e.tmo  = t;
    exp_rsp.push_back(e);
  endtask

  task automatic push_req(input logic wr, input logic [31:0] a, input logic [3:0] be);
    req_t r;
    r.wr   = wr;
    r.addr = a;
    r.be   = be;
    exp_req.push_back(r);
  endtask

  initial begin
    int base_rsp;
    int base_req;
    int base_we;
    bus.cmd_valid      = 1'b0;
    bus.cmd_opcode     = 2'b00;
    bus.cmd_autoinc    = 1'b0;
    bus.cmd_byteEnable = 4'h0;
    bus.cmd_word       = '0;
    bus.ipcore_switch_ready = 1'b1;
    bus.dataOut        = '0;

    repeat (3) @(negedge clock);
    #1 check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;

    // SETADDR + WRITE with auto-increment
    push_rsp(32'h0, 1'b0);
    base_rsp = rsp_count;
    send_cmd(2'b01, 1'b1, 4'h0, 32'h4000_0000);
    wait_count("setaddr_rsp", 0, base_rsp + 1, 50);
    check("setaddr_cur_addr", bus.cur_addr, 32'h4000_0000);

    push_req(1'b1, 32'h4000_0000, 4'hF);
    push_rsp(32'h0, 1'b0);
    base_rsp = rsp_count;
    base_we  = we_count;
    send_cmd(2'b10, 1'b0, 4'hF, 32'hDEAD_BEEF);
    wait_count("write_rsp", 0, base_rsp + 1, 100);
    @(negedge clock);
    check("write_buf", buf_word, 32'hDEAD_BEEF);
    check("write_dma_cap", dma_wcap, 32'hDEAD_BEEF);
    check("write_we_pulses", 32'(we_count - base_we), 32'd1);
    check("write_cur_addr", bus.cur_addr, 32'h4000_0004);

    // READ returning data staged by the DMA
    dma_rdata = 32'h1234_5678;
    push_req(1'b0, 32'h4000_0004, 4'hF);
    push_rsp(32'h1234_5678, 1'b0);
    base_rsp = rsp_count;
    send_cmd(2'b11, 1'b0, 4'hF, 32'h0);
    wait_count("read_rsp", 0, base_rsp + 1, 100);
    @(negedge clock);
    check("read_cur_addr", bus.cur_addr, 32'h4000_0008);

    // DMA never goes idle: timeout at ISSUE, no request, address held
    dma_hold_low = 1'b1;
    repeat (2) @(negedge clock);
    push_rsp(32'h0, 1'b1);
    base_rsp = rsp_count;
    base_req = req_count;
    send_cmd(2'b11, 1'b0, 4'hF, 32'h0);
    wait_count("timeout_rsp", 0, base_rsp + 1, 3 * TO + 20);
    @(negedge clock);
    check("timeout_no_req", 32'(req_count - base_req), 32'd0);
    check("timeout_cur_addr", bus.cur_addr, 32'h4000_0008);
    dma_hold_low = 1'b0;
    repeat (2) @(negedge clock);

    // Address wrap on auto-increment
    push_rsp(32'h0, 1'b0);
    base_rsp = rsp_count;
    send_cmd(2'b01, 1'b1, 4'h0, 32'hFFFF_FFFC);
    wait_count("wrap_setaddr_rsp", 0, base_rsp + 1, 50);
    dma_rdata = 32'hA5A5_0001;
    push_req(1'b0, 32'hFFFF_FFFC, 4'h3);
    push_rsp(32'hA5A5_0001, 1'b0);
    base_rsp = rsp_count;
    send_cmd(2'b11, 1'b0, 4'h3, 32'h0);
    wait_count("wrap_read_rsp", 0, base_rsp + 1, 100);
    @(negedge clock);
    check("wrap_cur_addr", bus.cur_addr, 32'h0000_0000);

    // cmd_valid during WAIT_DONE is dropped
    dma_busy = 8;
    push_req(1'b1, 32'h0000_0000, 4'h5);
    push_rsp(32'h0, 1'b0);
    base_rsp = rsp_count;
    base_req = req_count;
    send_cmd(2'b10, 1'b0, 4'h5, 32'h1122_3344);
    wait_count("busy_req_seen", 1, base_req + 1, 50);
    repeat (4) @(negedge clock);
    bus.cmd_opcode  = 2'b11;
    bus.cmd_valid   = 1'b1;
    @(negedge clock);
    bus.cmd_valid   = 1'b0;
    wait_count("busy_rsp", 0, base_rsp + 1, 100);
    repeat (20) @(negedge clock);
    check("busy_one_rsp", 32'(rsp_count - base_rsp), 32'd1);
    check("busy_one_req", 32'(req_count - base_req), 32'd1);
    check("busy_cur_addr", bus.cur_addr, 32'h0000_0004);

    // Reset during WAIT_DONE aborts silently
    dma_busy = 20;
    push_req(1'b0, 32'h0000_0004, 4'hF);
    push_rsp(32'hFFFF_FFFF, 1'b0);
    base_req = req_count;
    send_cmd(2'b11, 1'b0, 4'hF, 32'h0);
    wait_count("abort_req_seen", 1, base_req + 1, 50);
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1 check_reset_outputs("abort");
    exp_rsp.delete();
    base_rsp = rsp_count;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("abort_no_rsp", 32'(rsp_count - base_rsp), 32'd0);
    check("abort_cur_addr", bus.cur_addr, 32'h0000_0000);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    check("final_req_queue", 32'(exp_req.size()), 32'd0);
    check("final_rsp_queue", 32'(exp_rsp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
